// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if
// Bundles the command, chunk-stream, MAC operand/psum and result signals of
// the MAC sequencer.
//   master : operand feeders, MAC array and result consumer (testbench side)
//   slave  : mac_seq_ctrl
// Signals:
//   start/num_chunk/busy           command port
//   in_valid/in_ready/a_in/b_in    chunk operand stream (16 lanes x bw)
//   mac_a/mac_b/mac_psum           MAC operand buses and registered partial sum
//   out_valid/out_ready/out_data   accumulated dot-product result
interface mac_seq_ctrl_if #(
    parameter int bw      = 8,
    parameter int bw_psum = 22,
    parameter int pr      = 16,
    parameter int cnt_bw  = 8,
    parameter int acc_bw  = 30
);
    logic                 start;
    logic [cnt_bw-1:0]    num_chunk;
    logic                 busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [pr*bw-1:0]     a_in;
    logic [pr*bw-1:0]     b_in;
    logic [pr*bw-1:0]     mac_a;
    logic [pr*bw-1:0]     mac_b;
    logic [bw_psum-1:0]   mac_psum;
    logic                 out_valid;
    logic                 out_ready;
    logic [acc_bw-1:0]    out_data;

    modport master (
        output start, num_chunk, in_valid, a_in, b_in, mac_psum, out_ready,
        input  busy, in_ready, mac_a, mac_b, out_valid, out_data
    );

    modport slave (
        input  start, num_chunk, in_valid, a_in, b_in, mac_psum, out_ready,
        output busy, in_ready, mac_a, mac_b, out_valid, out_data
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Sequences an N-chunk signed dot product through the 16-lane MAC array.
// Each accepted chunk is forwarded to the MAC operand buses in the cycle it
// is accepted; the MAC returns its partial sum one cycle later, which is
// sign-extended and added into a wide accumulator. The final sum is held on
// the result port until the consumer takes it.
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    mac_seq_ctrl_if.slave (command, chunk stream, MAC, result)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start with a non-zero chunk count
// LOAD  | accepting chunks, remaining counts down on each fire
// DRAIN | last chunk's psum returns from the MAC and is accumulated
// DONE  | result presented, held until out_ready
module mac_seq_ctrl #(
    parameter int bw      = 8,
    parameter int bw_psum = 22,
    parameter int pr      = 16,
    parameter int cnt_bw  = 8,
    parameter int acc_bw  = 30
) (
    input  logic          clk,
    input  logic          reset,
    mac_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [cnt_bw-1:0]   remaining;
    logic                v1;
    logic [acc_bw-1:0]   acc;
    logic [acc_bw-1:0]   acc_sum;
    logic                fire;
    logic                cmd_accept;

    logic                in_ready_c;
    logic                out_valid_c;
    logic                busy_c;

    assign fire       = bus.in_valid & in_ready_c;
    assign cmd_accept = (state == IDLE) && bus.start && (bus.num_chunk != '0);

    assign acc_sum = acc + {{(acc_bw-bw_psum){bus.mac_psum[bw_psum-1]}}, bus.mac_psum};

    // Operands are zero-gated so that non-fire cycles push zero products
    // through the MAC, which also flushes its product register after reset.
    assign bus.mac_a = fire ? bus.a_in : {(pr*bw){1'b0}};
    assign bus.mac_b = fire ? bus.b_in : {(pr*bw){1'b0}};

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.out_data  = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (cmd_accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && (remaining == cnt_bw'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_c    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
            v1        <= 1'b0;
            acc       <= '0;
        end else begin
            // v1 marks that mac_psum now holds the product of the chunk
            // accepted on the previous cycle.
            v1 <= fire;
            if (cmd_accept) begin
                remaining <= bus.num_chunk;
                acc       <= '0;
            end else begin
                if (fire) begin
                    remaining <= remaining - cnt_bw'(1);
                end
                if (v1) begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mac_seq_ctrl_if bus ();

    mac_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-lane signed MAC with a one-cycle product register.
    int psum_c;
    always_comb begin
        int ai;
        int bi;
        psum_c = 0;
        for (int i = 0; i < 16; i++) begin
            ai = $signed(bus.mac_a[8*i +: 8]);
            bi = $signed(bus.mac_b[8*i +: 8]);
            psum_c = psum_c + ai * bi;
        end
    end
    always_ff @(posedge clk) bus.mac_psum <= psum_c[21:0];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 30'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
    endtask

    task automatic test_single();
        bus.a_in = {16{8'h01}};
        bus.b_in = {16{8'h01}};
        bus.num_chunk = 8'd1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_c0_busy: got %b expected 0", bus.busy); end
        tick();
        bus.start = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b1)     begin errors++; $display("FAIL single_c1_busy: got %b expected 1", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_c1_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.mac_a !== {16{8'h01}}) begin errors++; $display("FAIL single_c1_mac_a: got %h expected all lanes 01", bus.mac_a); end
        tick();
        #1;
        checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL single_c2_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.mac_a !== 128'd0)   begin errors++; $display("FAIL single_c2_mac_a: got %h expected 0", bus.mac_a); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_c2_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b1)      begin errors++; $display("FAIL single_c2_busy: got %b expected 1", bus.busy); end
        tick();
        #1;
        checks++; if (bus.out_valid !== 1'b1)  begin errors++; $display("FAIL single_c3_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_data !== 30'd16) begin errors++; $display("FAIL single_c3_out_data: got %0d expected 16", bus.out_data); end
        checks++; if (bus.busy !== 1'b1)       begin errors++; $display("FAIL single_c3_busy: got %b expected 1", bus.busy); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_c4_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL single_c4_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_max_neg();
        int cyc;
        bus.a_in = {16{8'h80}};
        bus.b_in = {16{8'h80}};
        bus.num_chunk = 8'd3;
        bus.in_valid = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL maxneg_timeout: got out_valid=%b expected 1 within 20 cycles", bus.out_valid); end
        checks++; if (cyc != 5) begin errors++; $display("FAIL maxneg_latency: got cycle %0d expected 5", cyc); end
        checks++; if (bus.out_data !== 30'd786432) begin errors++; $display("FAIL maxneg_out_data: got %0d expected 786432", bus.out_data); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_bubbles();
        logic [9:0] pat;
        int fires;
        pat = 10'b1000100101;
        fires = 0;
        bus.a_in = {16{8'h02}};
        bus.b_in = {16{8'hFD}};
        bus.num_chunk = 8'd4;
        bus.in_valid = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            bus.in_valid = pat[k-1];
            #1;
            if (bus.in_valid && bus.in_ready) fires++;
            if (pat[k-1]) begin
                checks++; if (bus.mac_a !== {16{8'h02}}) begin errors++; $display("FAIL bubble_mac_a_fire c%0d: got %h expected lanes 02", k, bus.mac_a); end
                checks++; if (bus.mac_b !== {16{8'hFD}}) begin errors++; $display("FAIL bubble_mac_b_fire c%0d: got %h expected lanes FD", k, bus.mac_b); end
            end else begin
                checks++; if (bus.mac_a !== 128'd0) begin errors++; $display("FAIL bubble_mac_a_idle c%0d: got %h expected 0", k, bus.mac_a); end
                checks++; if (bus.mac_b !== 128'd0) begin errors++; $display("FAIL bubble_mac_b_idle c%0d: got %h expected 0", k, bus.mac_b); end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_c11_out_valid: got %b expected 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1)       begin errors++; $display("FAIL bubble_c12_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_data !== 30'(-384))   begin errors++; $display("FAIL bubble_out_data: got %0d expected -384", $signed(bus.out_data)); end
        checks++; if (fires != 4)                   begin errors++; $display("FAIL bubble_fires: got %0d expected 4", fires); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_done_hold();
        bus.a_in = {16{8'h01}};
        bus.b_in = {16{8'h01}};
        bus.num_chunk = 8'd1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.start = (k == 1 || k == 3);
            bus.in_valid = 1'b1;
            #1;
            checks++; if (bus.out_valid !== 1'b1)  begin errors++; $display("FAIL hold_out_valid k%0d: got %b expected 1", k, bus.out_valid); end
            checks++; if (bus.out_data !== 30'd16) begin errors++; $display("FAIL hold_out_data k%0d: got %0d expected 16", k, bus.out_data); end
            checks++; if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL hold_in_ready k%0d: got %b expected 0", k, bus.in_ready); end
            checks++; if (bus.mac_a !== 128'd0)    begin errors++; $display("FAIL hold_mac_a k%0d: got %h expected 0", k, bus.mac_a); end
            tick();
        end
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL hold_idle_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_idle_out_valid: got %b expected 0", bus.out_valid); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: got busy=%b expected 0", bus.busy); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_zero_chunks();
        bus.num_chunk = 8'd0;
        bus.in_valid = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL zero_busy k%0d: got %b expected 0", k, bus.busy); end
            checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL zero_in_ready k%0d: got %b expected 0", k, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid k%0d: got %b expected 0", k, bus.out_valid); end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bus.a_in = {16{8'h05}};
        bus.b_in = {16{8'h07}};
        bus.num_chunk = 8'd4;
        bus.in_valid = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b expected 0", bus.in_ready); end
        bus.a_in = {16{8'h01}};
        bus.b_in = {16{8'h01}};
        bus.num_chunk = 8'd1;
        bus.in_valid = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++; if (bus.out_valid !== 1'b1)  begin errors++; $display("FAIL abort_timeout: got out_valid=%b expected 1 within 20 cycles", bus.out_valid); end
        checks++; if (bus.out_data !== 30'd16) begin errors++; $display("FAIL abort_out_data: got %0d expected 16", $signed(bus.out_data)); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.num_chunk = '0;
        bus.in_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_single();
        test_max_neg();
        test_bubbles();
        test_done_hold();
        test_zero_chunks();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
